// File: rtl/sub8_pkg.sv
// Shared constants and types for the two-stage 8-bit subtractor.
// WIDTH must be even: the low half is subtracted in stage 1 and the high half in stage 2.
package sub8_pkg;

  localparam int WIDTH  = 8;
  localparam int HALF   = WIDTH / 2;

  localparam int LO_LSB = 0;
  localparam int LO_MSB = HALF - 1;
  localparam int HI_LSB = HALF;
  localparam int HI_MSB = WIDTH - 1;

  typedef logic [HALF-1:0]  half_t;
  typedef logic [WIDTH-1:0] word_t;

  // Stage-1 payload: the finished low half plus what the high half still needs.
  typedef struct packed {
    logic  b1;
    half_t lo_diff;
    half_t a_hi;
    half_t b_hi;
  } s1_t;

  localparam s1_t   S1_RST   = '0;
  localparam word_t WORD_RST = '0;
  localparam logic  BIT_RST  = 1'b0;

endpackage

// File: rtl/sub8_if.sv
// Valid/ready operand and result bus of sub8_pipeline.
// The ovf wire exists only when SUB8_OVF_EN is defined.
interface sub8_if;
  import sub8_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t cina;
  word_t cinb;
  logic  bin;
  logic  out_valid;
  logic  out_ready;
  word_t diff;
  logic  bout;
`ifdef SUB8_OVF_EN
  logic  ovf;
`endif

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, cina, cinb, bin, out_ready,
`ifdef SUB8_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

  // Subtractor side.
  modport slave (
    input  in_valid, cina, cinb, bin, out_ready,
`ifdef SUB8_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/sub8_sub_half.sv
// Combinational HALF-bit subtract with borrow in and borrow out.
// One instance per pipeline stage.
module sub_half
  import sub8_pkg::*;
(
  input  half_t a,
  input  half_t b,
  input  logic  bi,
  output half_t d,
  output logic  bo
);

  // Widen by one bit so the borrow appears as the top bit of the result.
  always_comb begin
    {bo, d} = {1'b0, a} - {1'b0, b} - (HALF+1)'(bi);
  end

endmodule

// File: rtl/sub8_pipeline.sv
// Two-stage pipelined subtractor: {bout,diff} = cina - cinb - bin.
// Stage 1 subtracts the low half, stage 2 the high half using the stored borrow.
// Optional signed-overflow output enabled by defining SUB8_OVF_EN.
module sub8_pipeline
  import sub8_pkg::*;
(
  input logic   clk_100M,
  input logic   rst_n,
  sub8_if.slave bus
);

  s1_t   s1_q;
  logic  s1_valid;
  logic  out_valid_q;
  word_t diff_q;
  logic  bout_q;
`ifdef SUB8_OVF_EN
  logic  ovf_q;
  logic  ovf_c;
`endif

  logic  adv1;
  logic  adv2;
  half_t lo_diff_c;
  logic  b1_c;
  half_t hi_diff_c;
  logic  bout_c;

  sub_half u_lo (
    .a  (bus.cina[LO_MSB:LO_LSB]),
    .b  (bus.cinb[LO_MSB:LO_LSB]),
    .bi (bus.bin),
    .d  (lo_diff_c),
    .bo (b1_c)
  );

  sub_half u_hi (
    .a  (s1_q.a_hi),
    .b  (s1_q.b_hi),
    .bi (s1_q.b1),
    .d  (hi_diff_c),
    .bo (bout_c)
  );

  // Advance enables: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv2 = !out_valid_q || bus.out_ready;
    adv1 = !s1_valid || adv2;
  end

`ifdef SUB8_OVF_EN
  // Borrow into the MSB is a^b^d at that bit; overflow when it differs from bout.
  always_comb begin
    ovf_c = s1_q.a_hi[HALF-1] ^ s1_q.b_hi[HALF-1] ^ hi_diff_c[HALF-1] ^ bout_c;
  end
`endif

  // Stage 1 register: low-half result and high-half operands on accept.
  // NOTE: sequential state uses <= so every register samples pre-edge values;
  //       data registers are reset too, so outputs read 0 after reset, not X.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= BIT_RST;
      s1_q     <= S1_RST;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q <= '{b1:      b1_c,
                  lo_diff: lo_diff_c,
                  a_hi:    bus.cina[HI_MSB:HI_LSB],
                  b_hi:    bus.cinb[HI_MSB:HI_LSB]};
      end
    end
  end

  // Stage 2 register: complete difference and borrow out; holds while stalled.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= BIT_RST;
      diff_q      <= WORD_RST;
      bout_q      <= BIT_RST;
`ifdef SUB8_OVF_EN
      ovf_q       <= BIT_RST;
`endif
    end else if (adv2) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        diff_q <= {hi_diff_c, s1_q.lo_diff};
        bout_q <= bout_c;
`ifdef SUB8_OVF_EN
        ovf_q  <= ovf_c;
`endif
      end
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SUB8_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
